// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants and the multiply/divide sequencer state encoding.
package rv32_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned radix-2 shift/add multiplier and restoring divider sharing one
// 2*XLEN accumulator: {remainder, quotient} when dividing, product when multiplying.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_op_a,
    input  logic [XLEN-1:0]   i_op_b,
    output logic [2*XLEN-1:0] o_acc_next,
    output logic              o_last
);

    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic [CW-1:0]     r_cnt;
    logic              r_is_div;

    logic [XLEN:0]     w_add;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_div_next;

    // Multiply: conditionally add multiplicand into the high half, then shift right.
    assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opb : {XLEN{1'b0}})};
    assign w_mul_next = {w_add, r_acc[XLEN-1:1]};

    // Divide: shift next dividend bit into the remainder, subtract if it fits.
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_opb});
    assign w_diff     = w_rem_sh[XLEN-1:0] - r_opb;
    assign w_div_next = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                             : {r_acc[2*XLEN-2:0], 1'b0};

    assign o_acc_next = r_is_div ? w_div_next : w_mul_next;
    assign o_last     = (r_cnt == CW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc    <= {{XLEN{1'b0}}, i_op_a};
            r_opb    <= i_op_b;
            r_is_div <= i_is_div;
        end else if (i_step) begin
            r_acc    <= o_acc_next;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer for the execute stage: decodes M-ops, stalls
// the front end while muldiv_core iterates, and presents a registered result.
module muldiv_seq
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_exe,
    input  logic [XLEN-1:0] data_a_exe,
    input  logic [XLEN-1:0] data_b_exe,
    input  logic            flush,
    input  logic            hold,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    muldiv_state_t r_state;
    muldiv_state_t w_state_nxt;

    logic [2:0]      r_f3;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    logic [2:0]        w_f3;
    logic              w_is_mop;
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_detect;
    logic              w_start;
    logic              w_step;
    logic              w_last;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_f3     = instr_exe[14:12];
    assign w_is_mop = (instr_exe[6:0] == OPC_OP) && (instr_exe[31:25] == FUNCT7_MULDIV);
    assign w_is_div = w_f3[2];

    assign w_a_signed = (w_f3 == F3_MUL) || (w_f3 == F3_MULH) || (w_f3 == F3_MULHSU)
                     || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    assign w_b_signed = (w_f3 == F3_MUL) || (w_f3 == F3_MULH)
                     || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    assign w_sa       = w_a_signed && data_a_exe[XLEN-1];
    assign w_sb       = w_b_signed && data_b_exe[XLEN-1];
    assign w_abs_a    = w_sa ? (-data_a_exe) : data_a_exe;
    assign w_abs_b    = w_sb ? (-data_b_exe) : data_b_exe;

    // Divide-by-zero and signed overflow resolve without iterating.
    assign w_div0    = w_is_div && (data_b_exe == '0);
    assign w_ovf     = ((w_f3 == F3_DIV) || (w_f3 == F3_REM))
                    && (data_a_exe == {1'b1, {(XLEN-1){1'b0}}})
                    && (data_b_exe == {XLEN{1'b1}});
    assign w_special = w_div0 || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = w_f3[1] ? data_a_exe : {XLEN{1'b1}};
        end else if (w_ovf) begin
            w_special_res = w_f3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    assign w_detect = (r_state == ST_IDLE) && w_is_mop && !flush;
    assign w_start  = w_detect && !w_special;
    assign w_step   = (r_state == ST_RUN) && !flush;

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_step     (w_step),
        .i_is_div   (w_is_div),
        .i_op_a     (w_abs_a),
        .i_op_b     (w_abs_b),
        .o_acc_next (w_acc_next),
        .o_last     (w_last)
    );

    // Sign correction on the final iteration's accumulator value.
    assign w_prod = r_neg_q ? (-w_acc_next) : w_acc_next;
    assign w_quo  = r_neg_q ? (-w_acc_next[XLEN-1:0]) : w_acc_next[XLEN-1:0];
    assign w_rem  = r_neg_r ? (-w_acc_next[2*XLEN-1:XLEN]) : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        if (r_f3[2]) begin
            w_final = r_f3[1] ? w_rem : w_quo;
        end else if (r_f3 == F3_MUL) begin
            w_final = w_prod[XLEN-1:0];
        end else begin
            w_final = w_prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_detect) w_state_nxt = w_special ? ST_DONE : ST_RUN;
                ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
                ST_DONE: if (!hold)    w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall        = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            ST_IDLE: stall        = w_is_mop && !flush;
            ST_RUN:  stall        = 1'b1;
            ST_DONE: result_valid = !flush;
            default: begin
                stall        = 1'b0;
                result_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_detect) begin
            r_f3    <= w_f3;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_detect && w_special) begin
            r_result <= w_special_res;
        end else if (w_step && w_last) begin
            r_result <= w_final;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed RV32M results, stall lengths,
// flush, hold and reset behaviour.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic [31:0] instr_exe;
    logic [31:0] data_a_exe;
    logic [31:0] data_b_exe;
    logic        flush;
    logic        hold;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;

    int n_checks;
    int n_fail;

    localparam logic [31:0] ADD = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

    muldiv_seq #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_exe    (instr_exe),
        .data_a_exe   (data_a_exe),
        .data_b_exe   (data_b_exe),
        .flush        (flush),
        .hold         (hold),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mop(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op in an IDLE cycle and follows it through DONE and back to IDLE.
    task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_stall, input int hold_n);
        int n;
        instr_exe  = ins;
        data_a_exe = a;
        data_b_exe = b;
        #1;
        check({tag, "_detect_stall"}, 32'(stall), 32'd1);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!stall) break;
            n++;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        for (int k = 0; k <= hold_n; k++) begin
            hold = (k < hold_n);
            #1;
            check({tag, "_valid"}, 32'(result_valid), 32'd1);
            check({tag, "_result"}, result, exp);
            if (k > 0) check({tag, "_done_stall"}, 32'(stall), 32'd0);
            if (k < hold_n) step();
        end
        hold      = 1'b0;
        instr_exe = ADD;
        step();
        check({tag, "_post_stall"}, 32'(stall), 32'd0);
        check({tag, "_post_valid"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        int bad;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        hold       = 1'b0;
        instr_exe  = ADD;
        data_a_exe = '0;
        data_b_exe = '0;
        repeat (3) step();
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_result", result, 32'h0);
        rst = 1'b0;
        step();

        run_op("mul",    mop(3'b000), 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        run_op("mulh",   mop(3'b001), 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
        run_op("mulhsu", mop(3'b010), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
        run_op("div",    mop(3'b100), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("rem",    mop(3'b110), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("divu",   mop(3'b101), 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("remu",   mop(3'b111), 32'd100, 32'd7, 32'd2, 33, 0);
        run_op("divu0",  mop(3'b101), 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem0",   mop(3'b110), 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 0);
        run_op("divovf", mop(3'b100), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("removf", mop(3'b110), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

        // Flush in the middle of a multiply.
        instr_exe  = mop(3'b000);
        data_a_exe = 32'd7;
        data_b_exe = 32'd9;
        #1;
        check("flush_detect_stall", 32'(stall), 32'd1);
        repeat (10) step();
        flush = 1'b1;
        #1;
        check("flush_cycle_stall", 32'(stall), 32'd1);
        step();
        flush     = 1'b0;
        instr_exe = ADD;
        #1;
        check("flush_after_stall", 32'(stall), 32'd0);
        check("flush_after_valid", 32'(result_valid), 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (stall !== 1'b0 || result_valid !== 1'b0) bad++;
        end
        check("flush_add_quiet", 32'(bad), 32'd0);

        // Hold in DONE, then a back-to-back op.
        run_op("divu_hold", mop(3'b101), 32'd100, 32'd7, 32'd14, 33, 3);
        run_op("mulhu",     mop(3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);

        // Reset in the middle of a divide.
        instr_exe  = mop(3'b101);
        data_a_exe = 32'd1000;
        data_b_exe = 32'd3;
        #1;
        check("rstrun_detect_stall", 32'(stall), 32'd1);
        repeat (5) step();
        rst       = 1'b1;
        instr_exe = ADD;
        step();
        rst = 1'b0;
        #1;
        check("rstrun_stall", 32'(stall), 32'd0);
        check("rstrun_result", result, 32'h0);
        check("rstrun_valid", 32'(result_valid), 32'd0);

        run_op("after_rst", mop(3'b101), 32'd1000, 32'd3, 32'd333, 33, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
